// File: rtl/sr_rand_source_if.sv
// Consumer-side handshake bundle for the stochastic-rounding random word source.
// master = the source, slave = the rounding stage pulling words.
interface sr_rand_source_if #(
  parameter int unsigned num_round_bits = 10,
  parameter int unsigned fifo_depth     = 4
) ();

  logic                              rand_valid;
  logic                              rand_ready;
  logic [num_round_bits-1:0]         rand_out;
  logic [$clog2(fifo_depth):0]       fill_level;

  modport master (
    output rand_valid,
    output rand_out,
    output fill_level,
    input  rand_ready
  );

  modport slave (
    input  rand_valid,
    input  rand_out,
    input  fill_level,
    output rand_ready
  );

endinterface

// File: rtl/sr_rand_source.sv
// Galois-LFSR random word source feeding a small FIFO for stochastic rounding.
// Optional macro SR_RAND_FORCE_EN adds a rand_force override of the consumer-facing head word.
module sr_rand_source #(
  parameter int unsigned num_round_bits = 10,
  parameter int unsigned fifo_depth     = 4,
  parameter logic [31:0] lfsr_mask      = 32'h8020_0003,
  parameter logic [31:0] reset_seed     = 32'h0000_0001
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      seed_load,
  input  logic [31:0]               seed,
`ifdef SR_RAND_FORCE_EN
  input  logic                      rand_force,
  input  logic [num_round_bits-1:0] rand_force_val,
`endif
  sr_rand_source_if.master          rand_if
);

  localparam int unsigned CntW  = (num_round_bits > 1) ? $clog2(num_round_bits) : 1;
  localparam int unsigned PtrW  = $clog2(fifo_depth);
  localparam int unsigned FillW = PtrW + 1;
  localparam int unsigned AsmW  = num_round_bits - 1;

  localparam logic [31:0]       ResetLfsr = (reset_seed == 32'h0) ? 32'h1 : reset_seed;
  localparam logic [CntW-1:0]   LastCnt   = CntW'(num_round_bits - 1);
  localparam logic [CntW-1:0]   CntOne    = CntW'(1);
  localparam logic [PtrW-1:0]   PtrOne    = PtrW'(1);
  localparam logic [FillW-1:0]  FillOne   = FillW'(1);
  localparam logic [FillW-1:0]  FullLvl   = FillW'(fifo_depth);
  localparam logic [FillW-1:0]  AlmostLvl = FillW'(fifo_depth - 1);

  typedef enum logic [0:0] {StGen, StStall} state_e;

  state_e                    state_q, state_d;
  logic [31:0]               lfsr_q, lfsr_d;
  logic [CntW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [AsmW-1:0]           asm_q, asm_d;
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0]          fill_q, fill_d;
  logic [num_round_bits-1:0] mem_q [fifo_depth];

  logic                      out_bit;
  logic [31:0]               lfsr_step;
  logic [num_round_bits-1:0] word;
  logic                      step;
  logic                      push;
  logic                      pop;
  logic                      full;
  logic                      fifo_valid;
  logic [num_round_bits-1:0] head;
  logic                      force_on;

`ifdef SR_RAND_FORCE_EN
  assign force_on = rand_force;
`else
  assign force_on = 1'b0;
`endif

  assign out_bit    = lfsr_q[0];
  assign lfsr_step  = (lfsr_q >> 1) ^ (out_bit ? lfsr_mask : 32'h0);
  assign word       = {asm_q, out_bit};
  assign full       = (fill_q == FullLvl);
  assign fifo_valid = (fill_q != '0);

  // A reseed discards whatever push/pop would otherwise have happened this cycle.
  assign step = (state_q == StGen) && !seed_load;
  assign push = step && (bit_cnt_q == LastCnt);
  assign pop  = fifo_valid && rand_if.rand_ready && !force_on && !seed_load;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    bit_cnt_d = bit_cnt_q;
    asm_d     = asm_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;

    if (seed_load) begin
      state_d   = StGen;
      lfsr_d    = (seed == 32'h0) ? 32'h1 : seed;
      bit_cnt_d = '0;
      asm_d     = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      fill_d    = '0;
    end else begin
      if (step) begin
        lfsr_d    = lfsr_step;
        asm_d     = word[AsmW-1:0];
        bit_cnt_d = push ? '0 : bit_cnt_q + CntOne;
      end

      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;

      unique case ({push, pop})
        2'b10:   fill_d = fill_q + FillOne;
        2'b01:   fill_d = fill_q - FillOne;
        default: fill_d = fill_q;
      endcase

      // Stall leaves only once the FIFO is seen non-full, i.e. the cycle after the pop.
      unique case (state_q)
        StGen:   if (push && !pop && (fill_q == AlmostLvl)) state_d = StStall;
        StStall: if (!full) state_d = StGen;
        default: state_d = StGen;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StGen;
      lfsr_q    <= ResetLfsr;
      bit_cnt_q <= '0;
      asm_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      bit_cnt_q <= bit_cnt_d;
      asm_q     <= asm_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

  assign head = fifo_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    rand_if.rand_valid = fifo_valid;
    rand_if.rand_out   = head;
    rand_if.fill_level = fill_q;
`ifdef SR_RAND_FORCE_EN
    if (rand_force) begin
      rand_if.rand_valid = 1'b1;
      rand_if.rand_out   = rand_force_val;
    end
`endif
  end

endmodule

// File: doc/sr_rand_source.md
SR_RAND_SOURCE -- requirements
Module: sr_rand_source

Interface
REQ-001 SHALL have parameter num_round_bits, default 10, width of each random word delivered to the stochastic-rounding stage.
REQ-002 SHALL have parameter fifo_depth, default 4, number of buffered random words; power of two, 2..16.
REQ-003 SHALL have parameter lfsr_mask, default 32'h8020_0003, Galois XOR mask.
REQ-004 SHALL have parameter reset_seed, default 32'h0000_0001, LFSR value loaded at reset.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port seed_load  input  1  synchronous reseed-and-flush strobe.
REQ-008 SHALL have port seed  input  32  new LFSR value, sampled when seed_load=1.
REQ-009 SHALL have port rand_ready  input  1  consumer accepts the head word.
REQ-010 SHALL have port rand_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port rand_out  output  num_round_bits  head word, valid when rand_valid=1.
REQ-012 SHALL have port fill_level  output  $clog2(fifo_depth)+1  current FIFO occupancy.

Function
REQ-013 SHALL step a 32-bit Galois LFSR once per cycle while generating: out_bit=lfsr[0]; lfsr<=(lfsr>>1)^(out_bit?lfsr_mask:0).
REQ-014 SHALL shift each out_bit into an assembly register from the LSB (first bit ends at the MSB) and count bits 0..num_round_bits-1.
REQ-015 SHALL, on the step where the count reaches num_round_bits-1, push {assembly[num_round_bits-2:0],out_bit} into the FIFO and reset the count to 0 in the same cycle.
REQ-016 SHALL be in exactly one of two states: GEN (stepping) or STALL (FIFO full at the start of the cycle; LFSR, count and assembly held).
REQ-017 SHALL go GEN->STALL when a push fills the FIFO; STALL->GEN in the cycle after a pop makes it non-full; a pop in a cycle the FIFO is full SHALL NOT permit a push in that same cycle.
REQ-018 SHALL pop the head when rand_valid && rand_ready; rand_ready with rand_valid=0 SHALL be ignored.
REQ-019 SHALL support simultaneous push and pop when not full: fill_level unchanged, ordering preserved.
REQ-020 SHALL drive rand_out combinationally from the FIFO head register and hold it stable while rand_valid=1 and no pop occurs.
REQ-021 SHALL wrap read/write pointers modulo fifo_depth.
REQ-022 SHALL, on seed_load=1, load the LFSR with seed (32'h1 if seed==0), empty the FIFO, clear count and assembly, enter GEN; any same-cycle pop or push SHALL be discarded; stepping resumes next cycle.
REQ-023 SHALL give first rand_valid=1 exactly num_round_bits cycles after reset release or seed_load.

Reset
REQ-024 SHALL, while resetn=0, asynchronously force lfsr=reset_seed (32'h1 if zero), count=0, assembly=0, pointers=0, state GEN.
REQ-025 SHALL reset outputs to rand_valid=0, rand_out=0, fill_level=0; reset mid-generation SHALL discard partial words and buffered words.

Configuration
REQ-026 SHALL, with macro SR_RAND_FORCE_EN defined, add inputs rand_force (1) and rand_force_val (num_round_bits); when rand_force=1, rand_valid=1 and rand_out=rand_force_val, pops ignored and FIFO/LFSR continue unaffected.
REQ-027 SHALL, without SR_RAND_FORCE_EN, omit both ports and behave per REQ-013..REQ-025 only.

Verification
REQ-028 Reset with default params, rand_ready=0 -> rand_valid rises after 10 cycles with rand_out=10'h36D; fill_level reaches 4 after 40 cycles, then STALL.
REQ-029 seed_load=1 with seed=32'h0 while FIFO holds 3 words -> fill_level=0 next cycle; after 10 cycles rand_out=10'h36D.
REQ-030 FIFO full, rand_ready=1 one cycle -> fill_level 4->3, next push occurs no earlier than 11 cycles later; words popped in push order.
REQ-031 rand_ready held 1 continuously -> one word popped per 10 cycles, fill_level toggles 0/1, never exceeds 1.
REQ-032 resetn pulsed low at bit count 5 with 2 words buffered -> all outputs 0 immediately; sequence restarts with first word 10'h36D.
REQ-033 SR_RAND_FORCE_EN defined, rand_force=1, rand_force_val=10'h3FF -> rand_out=10'h3FF, rand_valid=1; release -> original FIFO head and fill_level intact.
